// File: rtl/mac_feeder.sv
// Sequencer feeding mac_acc: walks pixel chunks and weight rows per neuron, 2-cycle address-to-beat latency.
// No backpressure; a tag pipe carries per-beat flags so neuron_done lines up with mac_acc's output.
module mac_feeder #(
  parameter int DW      = 128,
  parameter int CHUNKS  = 49,
  parameter int NEURONS = 10,
  parameter int MAC_LAT = 3,
  parameter int AW_P    = 6,
  parameter int AW_W    = 9
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  output logic [AW_P-1:0] pix_addr,
  output logic [AW_W-1:0] w_addr,
  input  logic [DW-1:0]   pix_rdata,
  input  logic [DW-1:0]   w_rdata,
  output logic [DW-1:0]   pixels,
  output logic [DW-1:0]   weights,
  output logic            data_vld,
  output logic            acc_clr,
  output logic            neuron_done,
  output logic [3:0]      neuron_idx,
  output logic            busy,
  output logic            done
);

  localparam int TD = MAC_LAT + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;

  typedef struct packed {
    logic       vld;
    logic       first;
    logic       last;
    logic [3:0] n;
  } tag_t;

  state_e          state_q, state_d;
  logic [AW_P-1:0] c_q, c_d;
  logic [3:0]      n_q, n_d;
  logic [AW_W-1:0] w_q, w_d;
  tag_t            tag_q [TD];
  tag_t            tag_new;
  tag_t            tail;
  logic [DW-1:0]   pix_q, wgt_q;
  logic            issuing, last_c, last_n, fin_hit;

  assign issuing = (state_q == ISSUE);
  assign last_c  = (c_q == AW_P'(CHUNKS - 1));
  assign last_n  = (n_q == 4'(NEURONS - 1));
  assign tail    = tag_q[TD-1];
  assign fin_hit = tail.vld && tail.last && (tail.n == 4'(NEURONS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = ISSUE;
        ISSUE:   if (last_c && last_n) state_d = DRAIN;
        DRAIN:   if (fin_hit) state_d = FIN;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == FIN);
    data_vld    = tag_q[1].vld;
    acc_clr     = tag_q[1].vld && tag_q[1].first;
    neuron_done = tail.vld && tail.last;
    neuron_idx  = tail.n;
    pix_addr    = c_q;
    w_addr      = w_q;
    pixels      = pix_q;
    weights     = wgt_q;
  end

  // w_q runs alongside c/n so the weight row address needs no multiplier.
  always_comb begin
    c_d = c_q;
    n_d = n_q;
    w_d = w_q;
    if (abort || !issuing || (last_c && last_n)) begin
      c_d = '0;
      n_d = '0;
      w_d = '0;
    end else if (last_c) begin
      c_d = '0;
      n_d = n_q + 4'd1;
      w_d = w_q + 1'b1;
    end else begin
      c_d = c_q + 1'b1;
      w_d = w_q + 1'b1;
    end
  end

  always_comb begin
    tag_new.vld   = issuing;
    tag_new.first = (c_q == '0);
    tag_new.last  = last_c;
    tag_new.n     = n_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_q <= '0;
      n_q <= '0;
      w_q <= '0;
    end else begin
      c_q <= c_d;
      n_q <= n_d;
      w_q <= w_d;
    end
  end

  // Stage 0 aligns with memory read data, stage 1 with the output beat, stage TD-1 with mac_acc's sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TD; i++) tag_q[i] <= '0;
    end else if (abort) begin
      for (int i = 0; i < TD; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_new;
      for (int i = 1; i < TD; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= '0;
      wgt_q <= '0;
    end else if (tag_q[0].vld && !abort) begin
      pix_q <= pix_rdata;
      wgt_q <= w_rdata;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with CHUNKS=4, NEURONS=2, MAC_LAT=3 and 1-cycle sync memory models.
module tb_mac_feeder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         abort;
  logic [5:0]   pix_addr;
  logic [8:0]   w_addr;
  logic [127:0] pix_rdata;
  logic [127:0] w_rdata;
  logic [127:0] pixels;
  logic [127:0] weights;
  logic         data_vld;
  logic         acc_clr;
  logic         neuron_done;
  logic [3:0]   neuron_idx;
  logic         busy;
  logic         done;

  logic [127:0] img  [0:3];
  logic [127:0] wrom [0:7];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_feeder #(
    .DW(128), .CHUNKS(4), .NEURONS(2), .MAC_LAT(3), .AW_P(6), .AW_W(9)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .pix_addr(pix_addr), .w_addr(w_addr),
    .pix_rdata(pix_rdata), .w_rdata(w_rdata),
    .pixels(pixels), .weights(weights),
    .data_vld(data_vld), .acc_clr(acc_clr),
    .neuron_done(neuron_done), .neuron_idx(neuron_idx),
    .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    pix_rdata <= img[pix_addr[1:0]];
    w_rdata   <= wrom[w_addr[2:0]];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start in the current cycle (cycle 0), then check cycles 1..15 against the hand-derived timeline:
  // addresses 1..8, beats 3..10, acc_clr 3/7, neuron_done 9/13, done 14, idle 15.
  task automatic run_img(input bit repulse, input int abort_cyc);
    bit live;
    bit iss;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      live = (abort_cyc < 0) || (k <= abort_cyc);
      iss  = live && (k <= 8);
      chk($sformatf("busy@%0d", k), 128'(busy), 128'(live && k <= 14));
      chk($sformatf("w_addr@%0d", k), 128'(w_addr), iss ? 128'(k - 1) : 128'(0));
      chk($sformatf("pix_addr@%0d", k), 128'(pix_addr), iss ? 128'((k - 1) % 4) : 128'(0));
      chk($sformatf("data_vld@%0d", k), 128'(data_vld), 128'(live && k >= 3 && k <= 10));
      chk($sformatf("acc_clr@%0d", k), 128'(acc_clr), 128'(live && (k == 3 || k == 7)));
      chk($sformatf("neuron_done@%0d", k), 128'(neuron_done), 128'(live && (k == 9 || k == 13)));
      chk($sformatf("done@%0d", k), 128'(done), 128'(live && k == 14));
      if (live && (k == 9 || k == 13))
        chk($sformatf("neuron_idx@%0d", k), 128'(neuron_idx), (k == 13) ? 128'(1) : 128'(0));
      if (live && k >= 3 && k <= 10) begin
        chk($sformatf("pixels@%0d", k), pixels, img[(k - 3) % 4]);
        chk($sformatf("weights@%0d", k), weights, wrom[k - 3]);
      end
      start = repulse && (k == 4 || k == 11 || k == 14);
      abort = (k == abort_cyc);
      if (k < 15) step();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) img[i]  = {8{16'hA000 + 16'(i)}};
    for (int j = 0; j < 8; j++) wrom[j] = {8{16'hB100 + 16'(j * 3)}};
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    #12;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_vld", 128'(data_vld), 128'(0));
    chk("rst_w_addr", 128'(w_addr), 128'(0));
    chk("rst_pixels", pixels, 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    reset_n = 1'b1;
    step();
    step();
    chk("idle_busy", 128'(busy), 128'(0));

    // Basic image, then a back-to-back image started in the IDLE cycle right after FIN.
    run_img(1'b0, -1);
    run_img(1'b0, -1);
    // start re-pulsed in ISSUE, DRAIN and FIN must not disturb the timeline.
    run_img(1'b1, -1);
    // abort in cycle 5, then a clean restart.
    run_img(1'b0, 5);
    step();
    run_img(1'b0, -1);

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy1", 128'(busy), 128'(0));
    step();
    chk("sa_busy2", 128'(busy), 128'(0));
    chk("sa_w_addr", 128'(w_addr), 128'(0));
    step();
    chk("sa_vld", 128'(data_vld), 128'(0));

    // Asynchronous reset mid-ISSUE, in a cycle where a beat is being presented.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_busy", 128'(busy), 128'(1));
    chk("pre_rst_vld", 128'(data_vld), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_vld", 128'(data_vld), 128'(0));
    chk("arst_clr", 128'(acc_clr), 128'(0));
    chk("arst_pix_addr", 128'(pix_addr), 128'(0));
    chk("arst_w_addr", 128'(w_addr), 128'(0));
    chk("arst_pixels", pixels, 128'(0));
    chk("arst_weights", weights, 128'(0));
    chk("arst_ndone", 128'(neuron_done), 128'(0));
    chk("arst_idx", 128'(neuron_idx), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("post_rst_busy@%0d", k), 128'(busy), 128'(0));
      chk($sformatf("post_rst_vld@%0d", k), 128'(data_vld), 128'(0));
      chk($sformatf("post_rst_ndone@%0d", k), 128'(neuron_done), 128'(0));
      chk($sformatf("post_rst_w_addr@%0d", k), 128'(w_addr), 128'(0));
    end
    run_img(1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
